// File: rtl/servo_frame_timebase.sv
// Servo frame timebase: prescaled free-running frame counter plus a
// frame-aligned PWM threshold (PULSE_MIN + clamped position sample).
// Optional stale-sample watchdog: define SERVO_FRAME_TIMEBASE_WATCHDOG_EN.
module servo_frame_timebase #(
  parameter int CLK_DIV      = 100,
  parameter int PERIOD_TICKS = 3000,
  parameter int PULSE_MIN    = 1000,
  parameter int PULSE_RANGE  = 1000,
  parameter int SAMPLE_W     = 10,
  parameter int CNT_W        = 12,
  parameter int WDOG_FRAMES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [CNT_W-1:0]    cntr_val,
  output logic [CNT_W-1:0]    x_val,
  output logic                tick,
  output logic                frame_start,
  output logic                sample_stale
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RANGE_C  = CNT_W'(PULSE_RANGE);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(PULSE_RANGE / 2);
  localparam logic [CNT_W-1:0] CENTRE_C = CNT_W'(PULSE_MIN + PULSE_RANGE / 2);

  // Parameter sanity: the threshold sum and the frame count must fit CNT_W.
  if (PULSE_MIN + PULSE_RANGE >= (1 << CNT_W)) begin : g_bad_sum
    $error("PULSE_MIN + PULSE_RANGE does not fit in CNT_W bits");
  end
  if (PERIOD_TICKS - 1 >= (1 << CNT_W)) begin : g_bad_period
    $error("PERIOD_TICKS-1 does not fit in CNT_W bits");
  end
  if (SAMPLE_W > CNT_W) begin : g_bad_sample_w
    $error("SAMPLE_W must not exceed CNT_W");
  end
  if (WDOG_FRAMES < 1 || CLK_DIV < 1 || PERIOD_TICKS < 2) begin : g_bad_cfg
    $error("WDOG_FRAMES, CLK_DIV must be >= 1 and PERIOD_TICKS >= 2");
  end

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             fs_q, fs_d;
  logic             presc_wrap, frame_wrap;
  logic [CNT_W-1:0] sample_ext, sample_clamped;

  assign sample_ext     = CNT_W'(sample_data);
  assign sample_clamped = (sample_ext > RANGE_C) ? RANGE_C : sample_ext;
  assign presc_wrap     = (presc_q == PS_W'(CLK_DIV - 1));
  assign frame_wrap     = presc_wrap && (cntr_q == CNT_W'(PERIOD_TICKS - 1));

`ifdef SERVO_FRAME_TIMEBASE_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_FRAMES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            seen_q, seen_d;
  logic            stale_q, stale_d;
`endif

  // Next-state: prescaler, frame counter, sample capture, frame-aligned threshold.
  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + PS_W'(1);
    tick_d  = presc_wrap;
    fs_d    = frame_wrap;
    cntr_d  = cntr_q;
    if (presc_wrap) begin
      cntr_d = frame_wrap ? '0 : cntr_q + CNT_W'(1);
    end
    pend_d = sample_valid ? sample_clamped : pend_q;
    x_d    = x_q;
    if (frame_wrap) begin
      // A sample arriving in the wrap cycle goes straight into the new frame.
      x_d = MIN_C + (sample_valid ? sample_clamped : pend_q);
    end
`ifdef SERVO_FRAME_TIMEBASE_WATCHDOG_EN
    wd_d    = wd_q;
    stale_d = stale_q;
    seen_d  = frame_wrap ? 1'b0 : (seen_q | sample_valid);
    if (sample_valid) begin
      wd_d    = '0;
      stale_d = 1'b0;
    end else if (frame_wrap && !seen_q) begin
      if (wd_q != WD_W'(WDOG_FRAMES)) begin
        wd_d = wd_q + WD_W'(1);
      end
      // Falling back to centre once, on the boundary the limit is reached.
      if (wd_q == WD_W'(WDOG_FRAMES - 1)) begin
        x_d     = CENTRE_C;
        pend_d  = HALF_C;
        stale_d = 1'b1;
      end
    end
`endif
  end

  // State registers with synchronous reset to the centred, idle timebase.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cntr_q  <= '0;
      tick_q  <= 1'b0;
      fs_q    <= 1'b0;
      pend_q  <= HALF_C;
      x_q     <= CENTRE_C;
    end else begin
      presc_q <= presc_d;
      cntr_q  <= cntr_d;
      tick_q  <= tick_d;
      fs_q    <= fs_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
    end
  end

`ifdef SERVO_FRAME_TIMEBASE_WATCHDOG_EN
  // Watchdog registers: stale-frame count, sample-seen flag, stale status.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      seen_q  <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      seen_q  <= seen_d;
      stale_q <= stale_d;
    end
  end
  assign sample_stale = stale_q;
`else
  assign sample_stale = 1'b0;
`endif

  assign cntr_val    = cntr_q;
  assign x_val       = x_q;
  assign tick        = tick_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_servo_frame_timebase.sv
// Bench for servo_frame_timebase with a short sim timebase (CLK_DIV=4, 30 ticks).
// Expected thresholds are queued per frame boundary; a monitor checks them on frame_start.
module tb_servo_frame_timebase;
  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 30;
  localparam int FRAME   = CLK_DIV * PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample_data = '0;
  logic [11:0] cntr_val, x_val;
  logic        tick, frame_start, sample_stale;

  servo_frame_timebase #(
    .CLK_DIV(CLK_DIV), .PERIOD_TICKS(PERIOD), .PULSE_MIN(1000), .PULSE_RANGE(1000),
    .SAMPLE_W(10), .CNT_W(12), .WDOG_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .cntr_val(cntr_val), .x_val(x_val), .tick(tick), .frame_start(frame_start),
    .sample_stale(sample_stale)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int stale; } exp_t;
  exp_t sb_q[$];

  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_seen = 1'b1;
  logic mon_en = 1'b0;
  int   x_prev = 0;

  // Clocks since reset release, and the reset level the DUT last sampled.
  always @(posedge clk) begin
    rst_seen <= rst;
    cyc      <= rst ? 0 : cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: timebase model every cycle, scoreboard pop on each frame_start.
  always @(negedge clk) begin
    if (mon_en && !rst_seen) begin
      check("tick", int'(tick), int'(cyc % CLK_DIV == 0 && cyc != 0));
      check("cntr", int'(cntr_val), (cyc / CLK_DIV) % PERIOD);
      check("frame_start", int'(frame_start), int'(cyc % FRAME == 0 && cyc != 0));
      if (frame_start) begin
        if (sb_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL sb_empty: frame_start with no expected entry (cyc %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("x_at_boundary", int'(x_val), e.x);
          check("stale_at_boundary", int'(sample_stale), e.stale);
        end
      end else begin
        check("x_hold", int'(x_val), x_prev);
      end
    end
    x_prev = int'(x_val);
  end

  task automatic push(input int x, input int stale);
    exp_t e;
    e.x = x;
    e.stale = stale;
    sb_q.push_back(e);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * FRAME);
    if (!frame_start) begin
      tests++;
      errors++;
      $display("FAIL fs_timeout: no frame_start within %0d clks", 2 * FRAME);
    end
  endtask

  // Returns #1 after the edge at which cyc reaches t.
  task automatic goto_cyc(input int t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t);
  endtask

  task automatic pulse(input int d);
    sample_data  = 10'(d);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cntr", int'(cntr_val), 0);
    check("rst_x", int'(x_val), 1500);
    check("rst_tick", int'(tick), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_stale", int'(sample_stale), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // First frame: centre threshold, first frame_start at clk 120.
    push(1500, 0);
    wait_fs();
    // Mid-frame sample only lands at the next boundary.
    push(1250, 0);
    goto_cyc(170);
    pulse(250);
    wait_fs();
    // Clamp plus last-wins within one frame.
    push(1400, 0);
    goto_cyc(250);
    pulse(1023);
    goto_cyc(260);
    pulse(400);
    wait_fs();
    // Single over-range sample clamps to PULSE_RANGE.
    push(2000, 0);
    goto_cyc(370);
    pulse(1023);
    wait_fs();
    // Sample coincident with the wrap cycle (edge 600) bypasses pending.
    push(1010, 0);
    goto_cyc(5 * FRAME - 1);
    pulse(10);
    wait_fs();
    // No new sample: the coincident value was retained.
    push(1010, 0);
    wait_fs();

    // Reset mid-frame at cntr_val=17 with 700 pending.
    goto_cyc(6 * FRAME + 10);
    pulse(700);
    goto_cyc(6 * FRAME + 17 * CLK_DIV);
    check("cntr_pre_rst", int'(cntr_val), 17);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cntr", int'(cntr_val), 0);
    check("midrst_x", int'(x_val), 1500);
    check("midrst_tick", int'(tick), 0);
    check("midrst_fs", int'(frame_start), 0);
    push(1500, 0);
    wait_fs();

    // Watchdog scenario: load 300, then two silent boundaries.
    push(1300, 0);
    goto_cyc(FRAME + 10);
    pulse(300);
    wait_fs();
`ifdef SERVO_FRAME_TIMEBASE_WATCHDOG_EN
    push(1300, 0);
    wait_fs();
    push(1500, 1);
    wait_fs();
    @(negedge clk);
    check("stale_held", int'(sample_stale), 1);
`else
    push(1300, 0);
    wait_fs();
    push(1300, 0);
    wait_fs();
`endif
    push(1100, 0);
    goto_cyc(4 * FRAME + 10);
    pulse(100);
    @(negedge clk);
    check("stale_cleared", int'(sample_stale), 0);
    wait_fs();

    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
